// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
//   SPI-slave (mode 0, MSB first) transaction sequencer between the chip pads
//   and the core register file. Runs entirely on the system clock: the SPI pad
//   signals are oversampled through synchronisers and their edges detected.
//   A command byte {rw, addr} is followed by one or more data bytes. Writes
//   issue a one-clk reg_we per byte; reads issue a one-clk reg_re and shift
//   the returned data out on miso.
//
//   Optional feature macro: SPI_AUTOINC_EN
//     defined   : burst mode, reg_addr increments (mod 2^ADDR_W) after every
//                 completed data byte; read prefetch targets addr+1.
//     undefined : reg_addr is fixed for the whole frame.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   sclk       in   SPI clock from pad (asynchronous)
//   cs_n       in   SPI chip select from pad, active low (asynchronous)
//   mosi       in   SPI data in from pad (asynchronous)
//   miso       out  SPI data out to pad, always driven
//   reg_addr   out  register address, stable while a strobe is high
//   reg_wdata  out  write data, valid with reg_we
//   reg_we     out  one-clk write strobe
//   reg_re     out  one-clk read strobe
//   reg_rdata  in   read data, valid one clk after reg_re
//   busy       out  high while a frame is being processed
// -----------------------------------------------------------------------------
module spi_reg_ctrl #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  localparam int                BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0]  LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_e;

  // One extra flop beyond the synchroniser holds the previous synced value
  // for edge detection. These track the pads continuously and are not reset,
  // so a frame already in progress at reset release never shows a cs_n fall.
  logic [SYNC_STAGES:0]   sclk_sync_q;
  logic [SYNC_STAGES:0]   cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  always_ff @(posedge clk) begin
    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], sclk};
    cs_sync_q   <= {cs_sync_q[SYNC_STAGES-1:0], cs_n};
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_high, mosi_s;
  assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_sync_q[SYNC_STAGES];
  assign cs_fall   = ~cs_sync_q[SYNC_STAGES-1] & cs_sync_q[SYNC_STAGES];
  assign cs_high   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

  state_e            state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              miso_q, miso_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              cap_q, cap_d;
  logic [DATA_W-1:0] byte_w;
  logic              byte_done;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    cap_d     = re_q;       // read data arrives one clk after the strobe
    byte_done = 1'b0;
    byte_w    = {rx_q, mosi_s};

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (cs_fall) state_d = CMD;
      end
      default: begin
        if (sclk_rise) begin
          rx_d = byte_w[DATA_W-2:0];
          if (bit_cnt_q == LAST) begin
            bit_cnt_d = '0;
            byte_done = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end

        if (byte_done) begin
          case (state_q)
            CMD: begin
              addr_d = byte_w[ADDR_W-1:0];
              if (byte_w[DATA_W-1]) begin
                re_d    = 1'b1;
                state_d = RDATA;
              end else begin
                state_d = WDATA;
              end
            end
            WDATA: begin
              wdata_d = byte_w;
              we_d    = 1'b1;
            end
            default: begin
              // Prefetch for the next byte so its MSB is ready for the
              // falling edge that closes the current byte.
              re_d = 1'b1;
`ifdef SPI_AUTOINC_EN
              addr_d = addr_q + ADDR_W'(1);
`endif
            end
          endcase
        end

        if (state_q == RDATA && sclk_fall) begin
          miso_d = tx_q[DATA_W-1];
          tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        end

        // A byte completing in the same clk as cs_n rising still issues its
        // strobe above; only the frame state is dropped here.
        if (cs_high) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end
      end
    endcase

    if (cap_q) tx_d = reg_rdata;

`ifdef SPI_AUTOINC_EN
    // Write addresses advance the clk after the strobe so reg_addr stays
    // stable while reg_we is high.
    if (we_q) addr_d = addr_q + ADDR_W'(1);
`endif

    if (state_d != RDATA) miso_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      miso_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      cap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      miso_q    <= miso_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      cap_q     <= cap_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_q <= rx_d;
    tx_q <= tx_d;
  end

  assign miso      = miso_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

`ifdef SPI_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef struct packed {
    logic       we;
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst, sclk, cs_n, mosi;
  logic       miso, reg_we, reg_re, busy;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;

  logic [7:0] regs [128];
  logic       pl_en;
  logic [6:0] pl_addr;
  logic [7:0] pl_data;

  int n_vec = 0;
  int n_bad = 0;
  int half  = 8;
  int both_cnt = 0;
  int rd_idx = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  always #5 clk = ~clk;

  spi_reg_ctrl #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  // Register-file model: read data returned one clk after reg_re.
  always @(posedge clk) begin
    if (reg_we) regs[reg_addr] <= reg_wdata;
    else if (pl_en) regs[pl_addr] <= pl_data;
    if (reg_re) reg_rdata <= regs[reg_addr];
  end

  // Strobe monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_we) obs_q.push_back({1'b1, reg_addr, reg_wdata});
      else if (reg_re) obs_q.push_back({1'b0, reg_addr, 8'h00});
      if (reg_we && reg_re) both_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      tick(half);
      r[i] = miso;
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    tick(half);
  endtask

  task automatic frame_end();
    tick(half);
    cs_n = 1'b1;
    tick(half + 4);
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; pl_en = 1'b0;
    tick(3);
    n_vec++;
    if ({miso, reg_addr, reg_wdata, reg_we, reg_re, busy} !== 19'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got miso=%b addr=%h wdata=%h we=%b re=%b busy=%b, want all 0",
               miso, reg_addr, reg_wdata, reg_we, reg_re, busy);
    end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_write();
    logic [7:0] r;
    exp_q.push_back({1'b1, 7'h05, 8'hA5});
    frame_start();
    spi_bits(8'h05, 8, r);
    n_vec++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL write_busy: got busy=%b, want 1", busy);
    end
    spi_bits(8'hA5, 8, r);
    frame_end();
    n_vec++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL write_busy_end: got busy=%b, want 0", busy);
    end
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (rd_idx >= obs_q.size()) begin
        n_bad++; $display("FAIL write_strobe: got none, want %h", e);
      end else begin
        if (obs_q[rd_idx] !== e) begin
          n_bad++; $display("FAIL write_strobe: got %h, want %h", obs_q[rd_idx], e);
        end
        rd_idx++;
      end
    end
    n_vec++;
    if (obs_q.size() != rd_idx) begin
      n_bad++; $display("FAIL write_extra: got %0d strobes, want %0d", obs_q.size(), rd_idx);
      rd_idx = obs_q.size();
    end
  endtask

  task automatic test_read();
    logic [7:0] r0, r1;
    pl_addr = 7'h05; pl_data = 8'h3C; pl_en = 1'b1;
    tick(1);
    pl_en = 1'b0;
    exp_q.push_back({1'b0, 7'h05, 8'h00});
    exp_q.push_back({1'b0, AUTOINC ? 7'h06 : 7'h05, 8'h00});
    frame_start();
    spi_bits(8'h85, 8, r0);
    spi_bits(8'h00, 8, r1);
    frame_end();
    n_vec++;
    if (r0 !== 8'h00) begin
      n_bad++; $display("FAIL read_cmd_miso: got %h, want 00", r0);
    end
    n_vec++;
    if (r1 !== 8'h3C) begin
      n_bad++; $display("FAIL read_data_miso: got %h, want 3c", r1);
    end
    n_vec++;
    if (miso !== 1'b0) begin
      n_bad++; $display("FAIL read_miso_idle: got %b, want 0", miso);
    end
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (rd_idx >= obs_q.size()) begin
        n_bad++; $display("FAIL read_strobe: got none, want %h", e);
      end else begin
        if (obs_q[rd_idx] !== e) begin
          n_bad++; $display("FAIL read_strobe: got %h, want %h", obs_q[rd_idx], e);
        end
        rd_idx++;
      end
    end
    n_vec++;
    if (obs_q.size() != rd_idx) begin
      n_bad++; $display("FAIL read_extra: got %0d strobes, want %0d", obs_q.size(), rd_idx);
      rd_idx = obs_q.size();
    end
  endtask

  task automatic test_abort();
    logic [7:0] r;
    frame_start();
    spi_bits(8'h05, 8, r);
    spi_bits(8'hF0, 4, r);
    frame_end();
    n_vec++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_busy: got %b, want 0", busy);
    end
    n_vec++;
    if (obs_q.size() != rd_idx) begin
      n_bad++; $display("FAIL abort_strobe: got %0d strobes, want 0", obs_q.size() - rd_idx);
      rd_idx = obs_q.size();
    end
    exp_q.push_back({1'b1, 7'h06, 8'h11});
    frame_start();
    spi_bits(8'h06, 8, r);
    spi_bits(8'h11, 8, r);
    frame_end();
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (rd_idx >= obs_q.size()) begin
        n_bad++; $display("FAIL abort_next_write: got none, want %h", e);
      end else begin
        if (obs_q[rd_idx] !== e) begin
          n_bad++; $display("FAIL abort_next_write: got %h, want %h", obs_q[rd_idx], e);
        end
        rd_idx++;
      end
    end
    n_vec++;
    if (obs_q.size() != rd_idx) begin
      n_bad++; $display("FAIL abort_extra: got %0d strobes, want %0d", obs_q.size(), rd_idx);
      rd_idx = obs_q.size();
    end
  endtask

  task automatic test_rst_midframe();
    logic [7:0] r;
    frame_start();
    spi_bits(8'h05, 3, r);
    rst = 1'b1;
    tick(2);
    n_vec++;
    if ({miso, reg_addr, reg_wdata, reg_we, reg_re, busy} !== 19'h0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got addr=%h wdata=%h we=%b re=%b busy=%b miso=%b, want all 0",
               reg_addr, reg_wdata, reg_we, reg_re, busy, miso);
    end
    rst = 1'b0;
    tick(2);
    spi_bits(8'h2A, 8, r);
    spi_bits(8'h55, 8, r);
    n_vec++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_busy: got %b, want 0", busy);
    end
    frame_end();
    n_vec++;
    if (obs_q.size() != rd_idx) begin
      n_bad++; $display("FAIL rst_mid_strobe: got %0d strobes, want 0", obs_q.size() - rd_idx);
      rd_idx = obs_q.size();
    end
  endtask

  task automatic test_autoinc();
    logic [7:0] r;
    exp_q.push_back({1'b1, 7'h7F, 8'h01});
    exp_q.push_back({1'b1, AUTOINC ? 7'h00 : 7'h7F, 8'h02});
    frame_start();
    spi_bits(8'h7F, 8, r);
    spi_bits(8'h01, 8, r);
    spi_bits(8'h02, 8, r);
    frame_end();
    n_vec++;
    if (reg_addr !== (AUTOINC ? 7'h01 : 7'h7F)) begin
      n_bad++; $display("FAIL autoinc_final_addr: got %h, want %h", reg_addr, AUTOINC ? 7'h01 : 7'h7F);
    end
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (rd_idx >= obs_q.size()) begin
        n_bad++; $display("FAIL autoinc_strobe: got none, want %h", e);
      end else begin
        if (obs_q[rd_idx] !== e) begin
          n_bad++; $display("FAIL autoinc_strobe: got %h, want %h", obs_q[rd_idx], e);
        end
        rd_idx++;
      end
    end
    n_vec++;
    if (obs_q.size() != rd_idx) begin
      n_bad++; $display("FAIL autoinc_extra: got %0d strobes, want %0d", obs_q.size(), rd_idx);
      rd_idx = obs_q.size();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r, rd;
    half = 4;
    exp_q.push_back({1'b1, 7'h01, 8'hC3});
    exp_q.push_back({1'b0, 7'h01, 8'h00});
    exp_q.push_back({1'b0, AUTOINC ? 7'h02 : 7'h01, 8'h00});
    frame_start();
    spi_bits(8'h01, 8, r);
    spi_bits(8'hC3, 8, r);
    frame_end();
    frame_start();
    spi_bits(8'h81, 8, r);
    spi_bits(8'h00, 8, rd);
    frame_end();
    n_vec++;
    if (rd !== 8'hC3) begin
      n_bad++; $display("FAIL b2b_readback: got %h, want c3", rd);
    end
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (rd_idx >= obs_q.size()) begin
        n_bad++; $display("FAIL b2b_strobe: got none, want %h", e);
      end else begin
        if (obs_q[rd_idx] !== e) begin
          n_bad++; $display("FAIL b2b_strobe: got %h, want %h", obs_q[rd_idx], e);
        end
        rd_idx++;
      end
    end
    n_vec++;
    if (obs_q.size() != rd_idx) begin
      n_bad++; $display("FAIL b2b_extra: got %0d strobes, want %0d", obs_q.size(), rd_idx);
      rd_idx = obs_q.size();
    end
    n_vec++;
    if (both_cnt != 0) begin
      n_bad++; $display("FAIL strobe_exclusive: got %0d clks with we and re high, want 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_rst_midframe();
    test_autoinc();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
